psum_acc_ctrl: RTL and testbench

PSUM_ACC_CTRL -- requirements
Module: psum_acc_ctrl

---
 rtl/psum_acc_ctrl.sv | 153 +++++++++++++++
 tb/tb_psum_acc_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_acc_ctrl.sv
// Partial-sum accumulation controller: read-modify-write of a psum scratchpad over P passes, then drain.
// Optional PSUM_SAT_EN: saturating adds instead of modulo-2^DW wrap.
module psum_acc_ctrl #(
  parameter int DW    = 16,
  parameter int AW    = 5,
  parameter int DEPTH = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] cfg_num_psum,
  input  logic [7:0]    cfg_passes,
  output logic          busy,
  output logic          done,
  output logic          cfg_err,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] spad_addr,
  output logic          spad_we,
  output logic [DW-1:0] spad_din,
  input  logic [DW-1:0] spad_dout
);
  typedef enum logic [2:0] {IDLE, ACC_WAIT, ACC_RD, ACC_WR, DR_RD, DR_OUT, FIN} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t        state_q;
  logic [AW-1:0] n_q, ptr_q, spad_addr_q;
  logic [7:0]    p_q, pass_q;
  logic [DW-1:0] data_q, out_data_q, spad_din_q;
  logic          busy_q, done_q, cfg_err_q, in_ready_q, out_valid_q, spad_we_q;

  logic          cfg_ok, ptr_last;
  logic [DW:0]   sum_wide;
  logic [DW-1:0] sum_d;

  assign cfg_ok   = (cfg_num_psum != '0) && ({1'b0, cfg_num_psum} <= DEPTH_L) && (cfg_passes != 8'd0);
  assign ptr_last = (ptr_q == n_q - AW'(1));

  // One extra bit exposes signed overflow: result sign bits disagree.
  always_comb begin
    sum_wide = {spad_dout[DW-1], spad_dout} + {data_q[DW-1], data_q};
    sum_d    = sum_wide[DW-1:0];
`ifdef PSUM_SAT_EN
    if (sum_wide[DW] != sum_wide[DW-1])
      sum_d = sum_wide[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      n_q         <= '0;
      p_q         <= '0;
      ptr_q       <= '0;
      pass_q      <= '0;
      data_q      <= '0;
      out_data_q  <= '0;
      spad_din_q  <= '0;
      spad_addr_q <= '0;
      spad_we_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      unique case (state_q)
        IDLE: if (start) begin
          if (cfg_ok) begin
            n_q        <= cfg_num_psum;
            p_q        <= cfg_passes;
            ptr_q      <= '0;
            pass_q     <= '0;
            busy_q     <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ACC_WAIT;
          end else begin
            cfg_err_q <= 1'b1;
          end
        end
        ACC_WAIT: if (in_valid) begin
          data_q      <= in_data;
          spad_addr_q <= ptr_q;
          spad_we_q   <= 1'b0;
          in_ready_q  <= 1'b0;
          state_q     <= ACC_RD;
        end
        ACC_RD: begin
          // First pass overwrites whatever a previous job left in the spad.
          spad_din_q <= (pass_q == 8'd0) ? data_q : sum_d;
          spad_we_q  <= 1'b1;
          state_q    <= ACC_WR;
        end
        ACC_WR: begin
          spad_we_q <= 1'b0;
          if (ptr_last) begin
            ptr_q  <= '0;
            pass_q <= pass_q + 8'd1;
            if (pass_q + 8'd1 == p_q) begin
              spad_addr_q <= '0;
              state_q     <= DR_RD;
            end else begin
              in_ready_q <= 1'b1;
              state_q    <= ACC_WAIT;
            end
          end else begin
            ptr_q      <= ptr_q + AW'(1);
            in_ready_q <= 1'b1;
            state_q    <= ACC_WAIT;
          end
        end
        DR_RD: begin
          out_data_q  <= spad_dout;
          out_valid_q <= 1'b1;
          state_q     <= DR_OUT;
        end
        DR_OUT: if (out_ready) begin
          out_valid_q <= 1'b0;
          if (ptr_last) begin
            state_q <= FIN;
          end else begin
            ptr_q       <= ptr_q + AW'(1);
            spad_addr_q <= ptr_q + AW'(1);
            state_q     <= DR_RD;
          end
        end
        FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign spad_addr = spad_addr_q;
  assign spad_we   = spad_we_q;
  assign spad_din  = spad_din_q;
endmodule

// File: tb/tb_psum_acc_ctrl.sv
// Scoreboard bench for psum_acc_ctrl: directed jobs push expected spad writes and drain words; negedge monitor checks.
module tb_psum_acc_ctrl;
  localparam int DW = 16, AW = 5, DEPTH = 24;

`ifdef PSUM_SAT_EN
  localparam logic [DW-1:0] E_POS = 16'h7FFF, E_NEG = 16'h8000;
`else
  localparam logic [DW-1:0] E_POS = 16'hE000, E_NEG = 16'h2000;
`endif

  logic          clk = 1'b0, rst_n = 1'b1, start = 1'b0;
  logic [AW-1:0] cfg_num_psum = '0;
  logic [7:0]    cfg_passes = '0;
  logic          busy, done, cfg_err;
  logic          in_valid = 1'b0, in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [AW-1:0] spad_addr;
  logic          spad_we;
  logic [DW-1:0] spad_din, spad_dout = '0;

  logic [DW-1:0]    mem [32];
  logic [DW-1:0]    exp_out[$];
  logic [AW+DW-1:0] exp_wr[$];
  logic [DW-1:0]    din[$];
  int errs = 0, checks = 0, cyc = 0;
  logic          hold_q = 1'b0;
  logic [DW-1:0] hold_data = '0;

  psum_acc_ctrl #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_psum(cfg_num_psum), .cfg_passes(cfg_passes),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .spad_addr(spad_addr), .spad_we(spad_we), .spad_din(spad_din), .spad_dout(spad_dout)
  );

  always #5 clk = ~clk;

  // Scratchpad model: write on rising edge, read data refreshed on falling edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (spad_we) mem[spad_addr] <= spad_din;
  end
  always @(negedge clk) spad_dout <= mem[spad_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errs++;
    $display("FAIL %s", nm);
  endtask

  // Monitor: inputs change only just after rising edges, so negedge values are what the next edge sees.
  always @(negedge clk) begin
    if (hold_q) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(hold_data));
    end
    hold_q    <= out_valid && !out_ready;
    hold_data <= out_data;
    if (out_valid && out_ready) begin
      if (exp_out.size() == 0) bad($sformatf("unexpected_out got %0h", out_data));
      else chk("out_data", 32'(out_data), 32'(exp_out.pop_front()));
    end
    if (spad_we) begin
      if (exp_wr.size() == 0) bad($sformatf("unexpected_spad_write addr %0d data %0h", spad_addr, spad_din));
      else chk("spad_write", 32'({spad_addr, spad_din}), 32'(exp_wr.pop_front()));
    end
  end

  task automatic nx;
    @(posedge clk);
    #1;
  endtask

  task automatic ew(input int a, input logic [DW-1:0] d);
    exp_wr.push_back({AW'(a), d});
  endtask

  task automatic chk_reset_outs;
    chk("reset_ctl", 32'({busy, done, cfg_err, in_ready, out_valid, spad_we, spad_addr}), 32'd0);
    chk("reset_data", {out_data, spad_din}, 32'd0);
  endtask

  task automatic job(input int n, input int p);
    int t_prev = -1;
    nx;
    start = 1'b1; cfg_num_psum = AW'(n); cfg_passes = 8'(p);
    nx;
    start = 1'b0;
    chk("busy_after_start", 32'(busy), 32'd1);
    foreach (din[i]) begin
      int k = 0;
      in_valid = 1'b1; in_data = din[i];
      while (!in_ready && k < 50) begin nx; k++; end
      if (!in_ready) bad("in_ready_timeout");
      nx;
      if (t_prev >= 0) chk("in_spacing", 32'(cyc - t_prev), 32'd3);
      t_prev = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic finish_job;
    int k = 0;
    while (!done && k < 300) begin nx; k++; end
    chk("done_seen", 32'(done), 32'd1);
    chk("busy_at_done", 32'(busy), 32'd0);
    nx;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("out_q_drained", 32'(exp_out.size()), 32'd0);
    chk("wr_q_drained", 32'(exp_wr.size()), 32'd0);
  endtask

  task automatic reject(input int n, input int p);
    nx;
    start = 1'b1; cfg_num_psum = AW'(n); cfg_passes = 8'(p);
    nx;
    start = 1'b0;
    chk("cfg_err_pulse", 32'(cfg_err), 32'd1);
    chk("busy_rejected", 32'(busy), 32'd0);
    nx;
    chk("cfg_err_clears", 32'(cfg_err), 32'd0);
    chk("busy_still_low", 32'(busy), 32'd0);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1 chk_reset_outs();
    nx; nx;
    rst_n = 1'b1;

    // N=3 P=1: single pass stores raw products
    din = {16'd5, 16'd6, 16'd7};
    ew(0, 16'd5); ew(1, 16'd6); ew(2, 16'd7);
    exp_out = {16'd5, 16'd6, 16'd7};
    job(3, 1); finish_job();

    // N=2 P=3: accumulate over three passes
    din = {16'd1, 16'd2, 16'd1, 16'd2, 16'd1, 16'd2};
    ew(0, 16'd1); ew(1, 16'd2); ew(0, 16'd2); ew(1, 16'd4); ew(0, 16'd3); ew(1, 16'd6);
    exp_out = {16'd3, 16'd6};
    job(2, 3); finish_job();

    // N=2 P=2: signed operands
    din = {16'hFFFD, 16'd5, 16'd1, 16'hFFF9};
    ew(0, 16'hFFFD); ew(1, 16'd5); ew(0, 16'hFFFE); ew(1, 16'hFFFE);
    exp_out = {16'hFFFE, 16'hFFFE};
    job(2, 2); finish_job();

    // N=1 P=2: positive overflow
    din = {16'h7000, 16'h7000};
    ew(0, 16'h7000); ew(0, E_POS);
    exp_out = {E_POS};
    job(1, 2); finish_job();

    // N=1 P=2: negative overflow
    din = {16'h9000, 16'h9000};
    ew(0, 16'h9000); ew(0, E_NEG);
    exp_out = {E_NEG};
    job(1, 2); finish_job();

    // Illegal configurations
    reject(0, 1);
    reject(25, 1);
    reject(3, 0);

    // Drain back-pressure: out_ready low for 5 cycles on first word
    out_ready = 1'b0;
    din = {16'd10, 16'd20};
    ew(0, 16'd10); ew(1, 16'd20);
    exp_out = {16'd10, 16'd20};
    job(2, 1);
    begin
      int k = 0;
      while (!out_valid && k < 50) begin nx; k++; end
      chk("out_valid_rises", 32'(out_valid), 32'd1);
    end
    repeat (5) nx;
    out_ready = 1'b1;
    nx;
    chk("taken_on_first_ready", 32'(out_valid), 32'd0);
    finish_job();

    // Reset in ACC_RD aborts the job; a fresh job follows
    nx;
    start = 1'b1; cfg_num_psum = AW'(2); cfg_passes = 8'd1;
    nx;
    start = 1'b0; in_valid = 1'b1; in_data = 16'd3;
    nx;
    rst_n = 1'b0;
    #1 chk_reset_outs();
    in_valid = 1'b0;
    nx;
    rst_n = 1'b1;
    din = {16'd4, 16'd9};
    ew(0, 16'd4); ew(1, 16'd9);
    exp_out = {16'd4, 16'd9};
    job(2, 1); finish_job();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
